mem_port_arbiter: RTL and testbench

- Two-master to one-slave AXI arbiter/sequencer that shares the single main-memory port between cacheA (m0) and cacheB (m1).
- Sits between the two cache controllers' downstream AXI ports and the main memory inside subsystem_mem.
- Serialises traffic: exactly one burst transaction (read or write) is in flight at a time.
- Master selection is round-robin; within a master, a pending write-back beats a pending refill.

---
 rtl/subsystem_pkg.sv | 17 +
 rtl/rr_arbiter2.sv | 36 +++
 rtl/mem_port_arbiter.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/subsystem_pkg.sv
// Shared types and constants for the memory subsystem arbiter.
package subsystem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        AW,
        W,
        B,
        AR,
        R
    } arb_state_e;

    localparam int NUM_MASTERS = 2;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin picker. Keeps the priority pointer and hands
// priority to the other master once a transaction completes.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       last_grant,
    output logic [1:0] win
);

    logic rr_ptr;
    logic other;

    assign other = ~rr_ptr;

    // Pointer moves to the master that did not just finish.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= 1'b0;
        end else if (update) begin
            rr_ptr <= ~last_grant;
        end
    end

    // The pointed-to master wins if it requests, otherwise the other one.
    always_comb begin
        win = 2'b00;
        if (req[rr_ptr]) begin
            win[rr_ptr] = 1'b1;
        end else if (req[other]) begin
            win[other] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-master to one-slave AXI arbiter. One burst is in flight at a time.
// Optional per-master performance counters are enabled by defining
// MEM_ARB_PERF_CNT_EN.
module mem_port_arbiter
    import subsystem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 1,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic [2*ADDR_WIDTH-1:0]    m_AWADDR,
    input  logic [2*8-1:0]             m_AWLEN,
    input  logic [2*3-1:0]             m_AWSIZE,
    input  logic [2*2-1:0]             m_AWBURST,
    input  logic [2*ID_WIDTH-1:0]      m_AWID,
    input  logic [1:0]                 m_AWVALID,
    output logic [1:0]                 m_AWREADY,
    input  logic [2*ADDR_WIDTH-1:0]    m_ARADDR,
    input  logic [2*8-1:0]             m_ARLEN,
    input  logic [2*3-1:0]             m_ARSIZE,
    input  logic [2*2-1:0]             m_ARBURST,
    input  logic [2*ID_WIDTH-1:0]      m_ARID,
    input  logic [1:0]                 m_ARVALID,
    output logic [1:0]                 m_ARREADY,
    input  logic [2*DATA_WIDTH-1:0]    m_WDATA,
    input  logic [2*STRB_WIDTH-1:0]    m_WSTRB,
    input  logic [1:0]                 m_WLAST,
    input  logic [1:0]                 m_WVALID,
    output logic [1:0]                 m_WREADY,
    output logic [2*ID_WIDTH-1:0]      m_BID,
    output logic [2*2-1:0]             m_BRESP,
    output logic [1:0]                 m_BVALID,
    input  logic [1:0]                 m_BREADY,
    output logic [2*ID_WIDTH-1:0]      m_RID,
    output logic [2*DATA_WIDTH-1:0]    m_RDATA,
    output logic [2*2-1:0]             m_RRESP,
    output logic [1:0]                 m_RLAST,
    output logic [1:0]                 m_RVALID,
    input  logic [1:0]                 m_RREADY,
    output logic [ADDR_WIDTH-1:0]      s_AWADDR,
    output logic [7:0]                 s_AWLEN,
    output logic [2:0]                 s_AWSIZE,
    output logic [1:0]                 s_AWBURST,
    output logic [ID_WIDTH-1:0]        s_AWID,
    output logic                       s_AWVALID,
    input  logic                       s_AWREADY,
    output logic [DATA_WIDTH-1:0]      s_WDATA,
    output logic [STRB_WIDTH-1:0]      s_WSTRB,
    output logic                       s_WLAST,
    output logic                       s_WVALID,
    input  logic                       s_WREADY,
    input  logic [ID_WIDTH-1:0]        s_BID,
    input  logic [1:0]                 s_BRESP,
    input  logic                       s_BVALID,
    output logic                       s_BREADY,
    output logic [ADDR_WIDTH-1:0]      s_ARADDR,
    output logic [7:0]                 s_ARLEN,
    output logic [2:0]                 s_ARSIZE,
    output logic [1:0]                 s_ARBURST,
    output logic [ID_WIDTH-1:0]        s_ARID,
    output logic                       s_ARVALID,
    input  logic                       s_ARREADY,
    input  logic [ID_WIDTH-1:0]        s_RID,
    input  logic [DATA_WIDTH-1:0]      s_RDATA,
    input  logic [1:0]                 s_RRESP,
    input  logic                       s_RLAST,
    input  logic                       s_RVALID,
    output logic                       s_RREADY,
    output logic [1:0]                 grant_o
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [2*32-1:0]            grant_cnt_o,
    output logic [2*32-1:0]            wait_cnt_o
`endif
);

    arb_state_e state, next_state;
    logic       gnt_idx;
    logic [1:0] req;
    logic [1:0] win;
    logic       win_idx;
    logic       txn_done;

    logic [ADDR_WIDTH-1:0] aw_addr  [NUM_MASTERS];
    logic [7:0]            aw_len   [NUM_MASTERS];
    logic [2:0]            aw_size  [NUM_MASTERS];
    logic [1:0]            aw_burst [NUM_MASTERS];
    logic [ID_WIDTH-1:0]   aw_id    [NUM_MASTERS];
    logic [ADDR_WIDTH-1:0] ar_addr  [NUM_MASTERS];
    logic [7:0]            ar_len   [NUM_MASTERS];
    logic [2:0]            ar_size  [NUM_MASTERS];
    logic [1:0]            ar_burst [NUM_MASTERS];
    logic [ID_WIDTH-1:0]   ar_id    [NUM_MASTERS];
    logic [DATA_WIDTH-1:0] w_data   [NUM_MASTERS];
    logic [STRB_WIDTH-1:0] w_strb   [NUM_MASTERS];
    logic [ID_WIDTH-1:0]   b_id     [NUM_MASTERS];
    logic [1:0]            b_resp   [NUM_MASTERS];
    logic [ID_WIDTH-1:0]   r_id     [NUM_MASTERS];
    logic [DATA_WIDTH-1:0] r_data   [NUM_MASTERS];
    logic [1:0]            r_resp   [NUM_MASTERS];

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_slice
        assign aw_addr[i]  = m_AWADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign aw_len[i]   = m_AWLEN[i*8 +: 8];
        assign aw_size[i]  = m_AWSIZE[i*3 +: 3];
        assign aw_burst[i] = m_AWBURST[i*2 +: 2];
        assign aw_id[i]    = m_AWID[i*ID_WIDTH +: ID_WIDTH];
        assign ar_addr[i]  = m_ARADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign ar_len[i]   = m_ARLEN[i*8 +: 8];
        assign ar_size[i]  = m_ARSIZE[i*3 +: 3];
        assign ar_burst[i] = m_ARBURST[i*2 +: 2];
        assign ar_id[i]    = m_ARID[i*ID_WIDTH +: ID_WIDTH];
        assign w_data[i]   = m_WDATA[i*DATA_WIDTH +: DATA_WIDTH];
        assign w_strb[i]   = m_WSTRB[i*STRB_WIDTH +: STRB_WIDTH];
        assign m_BID[i*ID_WIDTH +: ID_WIDTH]       = b_id[i];
        assign m_BRESP[i*2 +: 2]                   = b_resp[i];
        assign m_RID[i*ID_WIDTH +: ID_WIDTH]       = r_id[i];
        assign m_RDATA[i*DATA_WIDTH +: DATA_WIDTH] = r_data[i];
        assign m_RRESP[i*2 +: 2]                   = r_resp[i];
    end

    assign req     = m_AWVALID | m_ARVALID;
    assign win_idx = win[1];

    rr_arbiter2 u_rr (
        .clk        (ACLK),
        .reset      (ARESET),
        .req        (req),
        .update     (txn_done),
        .last_grant (gnt_idx),
        .win        (win)
    );

    // State register plus the latched owner of the transaction being started.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state   <= IDLE;
            gnt_idx <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && (|win)) begin
                gnt_idx <= win_idx;
            end
        end
    end

    // Next state and channel steering; everything is zero while in reset.
    always_comb begin
        next_state = state;
        txn_done   = 1'b0;
        grant_o    = 2'b00;
        s_AWADDR   = '0;
        s_AWLEN    = '0;
        s_AWSIZE   = '0;
        s_AWBURST  = '0;
        s_AWID     = '0;
        s_AWVALID  = 1'b0;
        s_WDATA    = '0;
        s_WSTRB    = '0;
        s_WLAST    = 1'b0;
        s_WVALID   = 1'b0;
        s_BREADY   = 1'b0;
        s_ARADDR   = '0;
        s_ARLEN    = '0;
        s_ARSIZE   = '0;
        s_ARBURST  = '0;
        s_ARID     = '0;
        s_ARVALID  = 1'b0;
        s_RREADY   = 1'b0;
        m_AWREADY  = 2'b00;
        m_ARREADY  = 2'b00;
        m_WREADY   = 2'b00;
        m_BVALID   = 2'b00;
        m_RVALID   = 2'b00;
        m_RLAST    = 2'b00;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            b_id[i]   = '0;
            b_resp[i] = AXI_RESP_OKAY;
            r_id[i]   = '0;
            r_data[i] = '0;
            r_resp[i] = AXI_RESP_OKAY;
        end
        if (!ARESET) begin
            if (state != IDLE) begin
                grant_o[gnt_idx] = 1'b1;
            end
            case (state)
                IDLE: begin
                    if (|win) begin
                        next_state = m_AWVALID[win_idx] ? AW : AR;
                    end
                end
                AW: begin
                    s_AWVALID          = m_AWVALID[gnt_idx];
                    s_AWADDR           = aw_addr[gnt_idx];
                    s_AWLEN            = aw_len[gnt_idx];
                    s_AWSIZE           = aw_size[gnt_idx];
                    s_AWBURST          = aw_burst[gnt_idx];
                    s_AWID             = aw_id[gnt_idx];
                    m_AWREADY[gnt_idx] = s_AWREADY;
                    if (s_AWVALID && s_AWREADY) begin
                        next_state = W;
                    end
                end
                W: begin
                    s_WVALID          = m_WVALID[gnt_idx];
                    s_WDATA           = w_data[gnt_idx];
                    s_WSTRB           = w_strb[gnt_idx];
                    s_WLAST           = m_WLAST[gnt_idx];
                    m_WREADY[gnt_idx] = s_WREADY;
                    if (s_WVALID && s_WREADY && s_WLAST) begin
                        next_state = B;
                    end
                end
                B: begin
                    m_BVALID[gnt_idx] = s_BVALID;
                    b_id[gnt_idx]     = s_BID;
                    b_resp[gnt_idx]   = s_BRESP;
                    s_BREADY          = m_BREADY[gnt_idx];
                    if (s_BVALID && s_BREADY) begin
                        next_state = IDLE;
                        txn_done   = 1'b1;
                    end
                end
                AR: begin
                    s_ARVALID          = m_ARVALID[gnt_idx];
                    s_ARADDR           = ar_addr[gnt_idx];
                    s_ARLEN            = ar_len[gnt_idx];
                    s_ARSIZE           = ar_size[gnt_idx];
                    s_ARBURST          = ar_burst[gnt_idx];
                    s_ARID             = ar_id[gnt_idx];
                    m_ARREADY[gnt_idx] = s_ARREADY;
                    if (s_ARVALID && s_ARREADY) begin
                        next_state = R;
                    end
                end
                R: begin
                    m_RVALID[gnt_idx] = s_RVALID;
                    m_RLAST[gnt_idx]  = s_RLAST;
                    r_id[gnt_idx]     = s_RID;
                    r_data[gnt_idx]   = s_RDATA;
                    r_resp[gnt_idx]   = s_RRESP;
                    s_RREADY          = m_RREADY[gnt_idx];
                    if (s_RVALID && s_RREADY && s_RLAST) begin
                        next_state = IDLE;
                        txn_done   = 1'b1;
                    end
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

`ifdef MEM_ARB_PERF_CNT_EN
    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_perf
        logic [31:0] grant_cnt;
        logic [31:0] wait_cnt;

        // Completed transactions and starved request cycles per master.
        always_ff @(posedge ACLK) begin
            if (ARESET) begin
                grant_cnt <= '0;
                wait_cnt  <= '0;
            end else begin
                if (txn_done && grant_o[i]) begin
                    grant_cnt <= grant_cnt + 32'd1;
                end
                if (req[i] && !grant_o[i]) begin
                    wait_cnt <= wait_cnt + 32'd1;
                end
            end
        end

        assign grant_cnt_o[i*32 +: 32] = grant_cnt;
        assign wait_cnt_o[i*32 +: 32]  = wait_cnt;
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; the bench plays both cache masters
// and the main-memory slave.
module tb_mem_port_arbiter;

    logic        ACLK;
    logic        ARESET;
    logic [63:0] m_AWADDR, m_ARADDR;
    logic [15:0] m_AWLEN, m_ARLEN;
    logic [5:0]  m_AWSIZE, m_ARSIZE;
    logic [3:0]  m_AWBURST, m_ARBURST;
    logic [1:0]  m_AWID, m_ARID, m_AWVALID, m_ARVALID, m_AWREADY, m_ARREADY;
    logic [63:0] m_WDATA;
    logic [7:0]  m_WSTRB;
    logic [1:0]  m_WLAST, m_WVALID, m_WREADY, m_BID, m_BVALID, m_BREADY;
    logic [3:0]  m_BRESP, m_RRESP;
    logic [1:0]  m_RID, m_RLAST, m_RVALID, m_RREADY;
    logic [63:0] m_RDATA;
    logic [31:0] s_AWADDR, s_ARADDR, s_WDATA, s_RDATA;
    logic [7:0]  s_AWLEN, s_ARLEN;
    logic [2:0]  s_AWSIZE, s_ARSIZE;
    logic [1:0]  s_AWBURST, s_ARBURST, s_BRESP, s_RRESP;
    logic [0:0]  s_AWID, s_ARID, s_BID, s_RID;
    logic [3:0]  s_WSTRB;
    logic        s_AWVALID, s_AWREADY, s_WLAST, s_WVALID, s_WREADY;
    logic        s_BVALID, s_BREADY, s_ARVALID, s_ARREADY;
    logic        s_RLAST, s_RVALID, s_RREADY;
    logic [1:0]  grant_o;
`ifdef MEM_ARB_PERF_CNT_EN
    logic [63:0] grant_cnt_o, wait_cnt_o;
`endif

    int errors = 0;
    int checks = 0;

    mem_port_arbiter dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .m_AWADDR(m_AWADDR), .m_AWLEN(m_AWLEN), .m_AWSIZE(m_AWSIZE),
        .m_AWBURST(m_AWBURST), .m_AWID(m_AWID), .m_AWVALID(m_AWVALID),
        .m_AWREADY(m_AWREADY),
        .m_ARADDR(m_ARADDR), .m_ARLEN(m_ARLEN), .m_ARSIZE(m_ARSIZE),
        .m_ARBURST(m_ARBURST), .m_ARID(m_ARID), .m_ARVALID(m_ARVALID),
        .m_ARREADY(m_ARREADY),
        .m_WDATA(m_WDATA), .m_WSTRB(m_WSTRB), .m_WLAST(m_WLAST),
        .m_WVALID(m_WVALID), .m_WREADY(m_WREADY),
        .m_BID(m_BID), .m_BRESP(m_BRESP), .m_BVALID(m_BVALID), .m_BREADY(m_BREADY),
        .m_RID(m_RID), .m_RDATA(m_RDATA), .m_RRESP(m_RRESP), .m_RLAST(m_RLAST),
        .m_RVALID(m_RVALID), .m_RREADY(m_RREADY),
        .s_AWADDR(s_AWADDR), .s_AWLEN(s_AWLEN), .s_AWSIZE(s_AWSIZE),
        .s_AWBURST(s_AWBURST), .s_AWID(s_AWID), .s_AWVALID(s_AWVALID),
        .s_AWREADY(s_AWREADY),
        .s_WDATA(s_WDATA), .s_WSTRB(s_WSTRB), .s_WLAST(s_WLAST),
        .s_WVALID(s_WVALID), .s_WREADY(s_WREADY),
        .s_BID(s_BID), .s_BRESP(s_BRESP), .s_BVALID(s_BVALID), .s_BREADY(s_BREADY),
        .s_ARADDR(s_ARADDR), .s_ARLEN(s_ARLEN), .s_ARSIZE(s_ARSIZE),
        .s_ARBURST(s_ARBURST), .s_ARID(s_ARID), .s_ARVALID(s_ARVALID),
        .s_ARREADY(s_ARREADY),
        .s_RID(s_RID), .s_RDATA(s_RDATA), .s_RRESP(s_RRESP), .s_RLAST(s_RLAST),
        .s_RVALID(s_RVALID), .s_RREADY(s_RREADY),
        .grant_o(grant_o)
`ifdef MEM_ARB_PERF_CNT_EN
        ,
        .grant_cnt_o(grant_cnt_o),
        .wait_cnt_o(wait_cnt_o)
`endif
    );

    // Free-running clock, 10 time units per cycle.
    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Hard stop in case a task loops forever.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clearInputs();
        m_AWADDR = '0; m_AWLEN = '0; m_AWSIZE = '0; m_AWBURST = '0; m_AWID = '0;
        m_AWVALID = '0; m_ARADDR = '0; m_ARLEN = '0; m_ARSIZE = '0; m_ARBURST = '0;
        m_ARID = '0; m_ARVALID = '0; m_WDATA = '0; m_WSTRB = '0; m_WLAST = '0;
        m_WVALID = '0; m_BREADY = '0; m_RREADY = '0;
        s_AWREADY = 0; s_WREADY = 0; s_BID = '0; s_BRESP = '0; s_BVALID = 0;
        s_ARREADY = 0; s_RID = '0; s_RDATA = '0; s_RRESP = '0; s_RLAST = 0; s_RVALID = 0;
    endtask

    task automatic applyReset();
        clearInputs();
        ARESET = 1'b1;
        tick();
        tick();
        ARESET = 1'b0;
        settle();
    endtask

    // Raise a write and/or read request on master m.
    task automatic applyStimulus(input int m, input bit wr, input bit rd,
                                 input logic [31:0] addr, input logic [7:0] len);
        if (wr) begin
            m_AWADDR[m*32 +: 32] = addr;
            m_AWLEN[m*8 +: 8]    = len;
            m_AWSIZE[m*3 +: 3]   = 3'd2;
            m_AWBURST[m*2 +: 2]  = 2'b01;
            m_AWID[m]            = m[0];
            m_AWVALID[m]         = 1'b1;
        end
        if (rd) begin
            m_ARADDR[m*32 +: 32] = addr;
            m_ARLEN[m*8 +: 8]    = len;
            m_ARSIZE[m*3 +: 3]   = 3'd2;
            m_ARBURST[m*2 +: 2]  = 2'b01;
            m_ARID[m]            = m[0];
            m_ARVALID[m]         = 1'b1;
        end
        settle();
    endtask

    // Act as the slave for one read burst owned by master m.
    task automatic serveRead(input int m, input logic [31:0] addr, input int len,
                             input logic [31:0] base, input int stall_at, input int stall_cycles);
        logic [1:0] oh;
        int n;
        oh = 2'(1 << m);
        n = 0;
        while (s_ARVALID !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            checkOutput("ar_timeout", 0, 1);
            return;
        end
        checkOutput("ar_grant", grant_o, oh);
        checkOutput("ar_addr", s_ARADDR, addr);
        checkOutput("ar_len", s_ARLEN, len[7:0]);
        s_ARREADY = 1'b1;
        settle();
        checkOutput("ar_ready", m_ARREADY, oh);
        tick();
        s_ARREADY = 1'b0;
        m_ARVALID[m] = 1'b0;
        m_RREADY = 2'b11;
        for (int beat = 0; beat <= len; beat++) begin
            s_RVALID = 1'b1;
            s_RDATA  = base + beat;
            s_RLAST  = (beat == len);
            s_RID    = m[0];
            if (beat == stall_at) begin
                m_RREADY[m] = 1'b0;
                settle();
                checkOutput("stall_rready", s_RREADY, 0);
                for (int k = 0; k < stall_cycles; k++) tick();
                checkOutput("stall_rvalid", m_RVALID, oh);
                m_RREADY = 2'b11;
            end
            settle();
            checkOutput("r_valid", m_RVALID, oh);
            checkOutput("r_data", m_RDATA[m*32 +: 32], base + beat);
            checkOutput("r_last", m_RLAST, (beat == len) ? oh : 2'b00);
            tick();
        end
        s_RVALID = 1'b0;
        s_RLAST  = 1'b0;
        m_RREADY = 2'b00;
        settle();
    endtask

    // Act as the slave for one write burst owned by master m.
    task automatic serveWrite(input int m, input logic [31:0] addr, input int len,
                              input logic [31:0] base);
        logic [1:0] oh;
        int n;
        oh = 2'(1 << m);
        n = 0;
        while (s_AWVALID !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            checkOutput("aw_timeout", 0, 1);
            return;
        end
        checkOutput("aw_grant", grant_o, oh);
        checkOutput("aw_addr", s_AWADDR, addr);
        s_AWREADY = 1'b1;
        settle();
        checkOutput("aw_ready", m_AWREADY, oh);
        tick();
        s_AWREADY = 1'b0;
        m_AWVALID[m] = 1'b0;
        s_WREADY = 1'b1;
        for (int beat = 0; beat <= len; beat++) begin
            m_WVALID[m]          = 1'b1;
            m_WDATA[m*32 +: 32]  = base + beat;
            m_WSTRB[m*4 +: 4]    = 4'hF;
            m_WLAST[m]           = (beat == len);
            settle();
            checkOutput("w_valid", s_WVALID, 1);
            checkOutput("w_data", s_WDATA, base + beat);
            checkOutput("w_last", s_WLAST, (beat == len));
            checkOutput("w_ready", m_WREADY, oh);
            tick();
        end
        m_WVALID = '0;
        m_WLAST  = '0;
        s_WREADY = 1'b0;
        s_BVALID = 1'b1;
        s_BID    = 1'b1;
        s_BRESP  = 2'b00;
        m_BREADY = 2'b11;
        settle();
        checkOutput("b_valid", m_BVALID, oh);
        checkOutput("b_id", m_BID, oh);
        checkOutput("b_ready", s_BREADY, 1);
        tick();
        s_BVALID = 1'b0;
        m_BREADY = 2'b00;
        settle();
    endtask

    initial begin
        // Reset state.
        applyReset();
        checkOutput("rst_grant", grant_o, 0);
        checkOutput("rst_m_ready", {m_AWREADY, m_ARREADY, m_WREADY}, 0);
        checkOutput("rst_m_valid", {m_BVALID, m_RVALID}, 0);
        checkOutput("rst_s_valid", {s_AWVALID, s_ARVALID, s_WVALID}, 0);
        checkOutput("rst_s_ready", {s_BREADY, s_RREADY}, 0);

        // Single read from m0; slave sees nothing in the request cycle.
        applyStimulus(0, 0, 1, 32'h0002_0000, 8'd3);
        checkOutput("req_cycle_arvalid", s_ARVALID, 0);
        checkOutput("req_cycle_grant", grant_o, 0);
        serveRead(0, 32'h0002_0000, 3, 32'h100, -1, 0);
        checkOutput("single_idle", grant_o, 0);

        // Simultaneous reads after reset: m0 first, idle bubble, then m1.
        applyReset();
        applyStimulus(0, 0, 1, 32'h0000_1000, 8'd1);
        applyStimulus(1, 0, 1, 32'h0000_2000, 8'd1);
        serveRead(0, 32'h0000_1000, 1, 32'h200, -1, 0);
        checkOutput("simul_bubble", grant_o, 2'b00);
        serveRead(1, 32'h0000_2000, 1, 32'h300, -1, 0);
        checkOutput("simul_idle", grant_o, 0);

        // m1 asks for write and read together: write goes first.
        applyStimulus(1, 1, 1, 32'h0000_5000, 8'd3);
        serveWrite(1, 32'h0000_5000, 3, 32'h0000_00A0);
        checkOutput("wf_bubble", grant_o, 0);
        serveRead(1, 32'h0000_5000, 3, 32'h400, -1, 0);

        // m0 read with 5 cycles of master back-pressure on beat 2.
        applyStimulus(0, 0, 1, 32'h0000_6000, 8'd3);
        serveRead(0, 32'h0000_6000, 3, 32'h500, 1, 5);

        // Reset during the second write beat, then a fresh m1 read.
        applyStimulus(0, 1, 0, 32'h0000_7000, 8'd3);
        tick();
        s_AWREADY = 1'b1;
        tick();
        s_AWREADY = 1'b0;
        m_AWVALID = '0;
        s_WREADY = 1'b1;
        m_WVALID[0] = 1'b1;
        m_WDATA[31:0] = 32'h11;
        tick();
        m_WDATA[31:0] = 32'h12;
        settle();
        checkOutput("mid_w_valid", s_WVALID, 1);
        ARESET = 1'b1;
        settle();
        checkOutput("rst_same_cycle_wvalid", s_WVALID, 0);
        tick();
        ARESET = 1'b0;
        settle();
        checkOutput("rst_after_grant", grant_o, 0);
        checkOutput("rst_after_wvalid", s_WVALID, 0);
        checkOutput("rst_after_wready", m_WREADY, 0);
        checkOutput("rst_after_bready", s_BREADY, 0);
        clearInputs();
        applyStimulus(1, 0, 1, 32'h0000_8000, 8'd1);
        serveRead(1, 32'h0000_8000, 1, 32'h600, -1, 0);

`ifdef MEM_ARB_PERF_CNT_EN
        // Three contended rounds; each master completes three reads.
        applyReset();
        checkOutput("perf_rst", grant_cnt_o, 0);
        for (int r = 0; r < 3; r++) begin
            applyStimulus(0, 0, 1, 32'h0000_9000, 8'd0);
            applyStimulus(1, 0, 1, 32'h0000_A000, 8'd0);
            serveRead(0, 32'h0000_9000, 0, 32'h700, -1, 0);
            serveRead(1, 32'h0000_A000, 0, 32'h800, -1, 0);
        end
        checkOutput("grant_cnt_m0", grant_cnt_o[31:0], 3);
        checkOutput("grant_cnt_m1", grant_cnt_o[63:32], 3);
        checkOutput("wait_cnt_m1_nz", (wait_cnt_o[63:32] != 0), 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
